// File: rtl/mem_access_ctrl_if.sv
// MEM-stage access bundle: pipeline-side load/store request, memory handshake and status.
// master = the access controller, slave = the pipeline/memory side driving it.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              MEM_R_en;
    logic              MEM_W_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              pipe_en;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              timeout_err;

    modport master (
        input  MEM_R_en, MEM_W_en, address, write_data, mem_rdata, mem_ack,
        output read_data, pipe_en, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
    );

    modport slave (
        output MEM_R_en, MEM_W_en, address, write_data, mem_rdata, mem_ack,
        input  read_data, pipe_en, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: freezes the pipeline, runs req/ack, releases for one cycle.
// Define MEM_TIMEOUT_EN to abort an ACCESS that sees no ack within TIMEOUT_CYCLES cycles.
module mem_access_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    state_t            state, state_nxt;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] rd_q, addr_q, wdata_q;
    logic              we_q;
    logic              req_in, ack_acc, timeout_hit;
    logic              pipe_en_c, mem_req_c;

    assign req_in  = bus.MEM_R_en | bus.MEM_W_en;
    assign ack_acc = (state == ACCESS) & bus.mem_ack;
    // wait_cnt counts the ACCESS cycles already completed, so the current cycle is wait_cnt+1.
    assign timeout_hit = TIMEOUT_EN && (state == ACCESS) && !bus.mem_ack &&
                         (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pipe_en_c = 1'b1;
        mem_req_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_in) begin
                    pipe_en_c = 1'b0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                pipe_en_c = 1'b0;
                mem_req_c = 1'b1;
                if (ack_acc || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: these are plain flops, not a memory array, so they take the async reset directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && req_in) begin
                addr_q   <= bus.address;
                wdata_q  <= bus.write_data;
                we_q     <= bus.MEM_W_en;  // R and W together resolve to a write
                wait_cnt <= '0;
            end else if (state == ACCESS && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (ack_acc && !we_q)  rd_q <= bus.mem_rdata;
            else if (timeout_hit)  rd_q <= DATA_W'(32'hDEAD_BEEF);
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              timeout_q <= 1'b0;
        else if (timeout_hit) timeout_q <= 1'b1;
    end

    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Reset forces the pipeline enabled even if a request is already presented.
    assign bus.pipe_en   = rst | pipe_en_c;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.read_data = rd_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, randomized transactions
// against a transaction-level model, and reset / timeout corner sequences.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] rd_model   = 32'h0;
    logic        terr_model = 1'b0;

    mem_access_ctrl_if #(.DATA_W(32)) bus ();

    mem_access_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;   // ACCESS cycles until ack (>= 1)
        int          gap;     // idle cycles before the request
        logic [31:0] exp_rd;
        logic        exp_we;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic w,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int delay, input int gap,
                                input logic [31:0] exp_rd, input logic exp_we);
        vec_t v;
        v.name = name; v.r = r; v.w = w; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.delay = delay; v.gap = gap; v.exp_rd = exp_rd; v.exp_we = exp_we;
        return v;
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, "_pipe_en"}, bus.pipe_en, 1);
        check({tag, "_req"}, bus.mem_req, 0);
        check({tag, "_rd_hold"}, bus.read_data, rd_model);
        check({tag, "_terr"}, bus.timeout_err, terr_model);
    endtask

    // One transaction: gap idle cycles (first one with a stray ack), the issue cycle,
    // delay ACCESS cycles ending in ack, then the single release cycle.
    task automatic run_txn(input vec_t v);
        for (int i = 0; i < v.gap; i++) begin
            @(negedge clk);
            bus.MEM_R_en  = 1'b0;
            bus.MEM_W_en  = 1'b0;
            bus.mem_ack   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            #1 idle_checks({v.name, "_gap"});
        end
        @(negedge clk);
        bus.MEM_R_en   = v.r;
        bus.MEM_W_en   = v.w;
        bus.address    = v.addr;
        bus.write_data = v.wdata;
        bus.mem_ack    = 1'b0;
        #1;
        check({v.name, "_issue_pipe_en"}, bus.pipe_en, 0);
        check({v.name, "_issue_req"}, bus.mem_req, 0);
        check({v.name, "_issue_rd"}, bus.read_data, rd_model);
        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            bus.address    = $urandom;  // latched copies must not follow the inputs
            bus.write_data = $urandom;
            bus.mem_ack    = (i == v.delay - 1);
            bus.mem_rdata  = (i == v.delay - 1) ? v.rdata : $urandom;
            #1;
            check({v.name, "_acc_req"}, bus.mem_req, 1);
            check({v.name, "_acc_pipe_en"}, bus.pipe_en, 0);
            check({v.name, "_acc_we"}, bus.mem_we, v.exp_we);
            check({v.name, "_acc_addr"}, bus.mem_addr, v.addr);
            check({v.name, "_acc_wdata"}, bus.mem_wdata, v.wdata);
        end
        @(negedge clk);
        bus.mem_ack   = 1'($urandom_range(0, 1));  // ignored outside ACCESS
        bus.mem_rdata = $urandom;
        #1;
        check({v.name, "_done_pipe_en"}, bus.pipe_en, 1);
        check({v.name, "_done_req"}, bus.mem_req, 0);
        check({v.name, "_done_rd"}, bus.read_data, v.exp_rd);
        check({v.name, "_done_terr"}, bus.timeout_err, terr_model);
        rd_model = v.exp_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("load",       1, 0, 32'h100, 32'h0,        32'h12345678, 3, 2, 32'h12345678, 0);
        vecs[1] = mk("store",      0, 1, 32'h040, 32'hCAFE0001, 32'h55555555, 1, 1, 32'h12345678, 1);
        vecs[2] = mk("b2b_load",   1, 0, 32'h200, 32'hAAAA0000, 32'h0BADF00D, 2, 1, 32'h0BADF00D, 0);
        vecs[3] = mk("b2b_store",  0, 1, 32'h204, 32'h11112222, 32'h33334444, 1, 0, 32'h0BADF00D, 1);
        vecs[4] = mk("both_en",    1, 1, 32'h300, 32'h77778888, 32'h9999AAAA, 2, 3, 32'h0BADF00D, 1);
        vecs[5] = mk("ack_at_lim", 1, 0, 32'h404, 32'h0,        32'hFEEDC0DE, 4, 1, 32'hFEEDC0DE, 0);

        // Reset with a request already presented: pipe_en must still read 1.
        rst            = 1'b1;
        bus.MEM_R_en   = 1'b1;
        bus.MEM_W_en   = 1'b0;
        bus.address    = 32'hFFFF_0000;
        bus.write_data = 32'h1234_5678;
        bus.mem_rdata  = 32'h0;
        bus.mem_ack    = 1'b0;
        #1;
        check("rst_pipe_en", bus.pipe_en, 1);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_rd", bus.read_data, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_terr", bus.timeout_err, 0);
        @(negedge clk);
        @(negedge clk);
        bus.MEM_R_en = 1'b0;
        rst          = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 idle_checks("idle");
        end

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int   kind;
            kind     = $urandom_range(0, 2);
            v.name   = "rand";
            v.r      = (kind != 1);
            v.w      = (kind != 0);
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.rdata  = $urandom;
            v.delay  = $urandom_range(1, 4);
            v.gap    = $urandom_range(0, 2);
            v.exp_we = v.w;
            v.exp_rd = (v.r && !v.w) ? v.rdata : rd_model;
            run_txn(v);
        end

        // Reset during the second ACCESS cycle, then a late ack in IDLE.
        @(negedge clk);
        bus.MEM_R_en = 1'b1;
        bus.MEM_W_en = 1'b0;
        bus.address  = 32'h500;
        bus.mem_ack  = 1'b0;
        #1 check("rstacc_issue_pipe_en", bus.pipe_en, 0);
        @(negedge clk);
        #1 check("rstacc_acc1_req", bus.mem_req, 1);
        @(negedge clk);
        #1 check("rstacc_acc2_req", bus.mem_req, 1);
        #1 rst = 1'b1;
        #1;
        check("rstacc_req_drop", bus.mem_req, 0);
        check("rstacc_pipe_en", bus.pipe_en, 1);
        check("rstacc_rd", bus.read_data, 0);
        check("rstacc_addr", bus.mem_addr, 0);
        bus.MEM_R_en = 1'b0;
        rd_model     = 32'h0;
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1 idle_checks("late_ack");
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1 idle_checks("after_late_ack");

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 4 ACCESS cycles with the poison value and a sticky flag.
        @(negedge clk);
        bus.MEM_R_en = 1'b1;
        bus.address  = 32'h600;
        #1 check("to_issue_pipe_en", bus.pipe_en, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("to_acc_req", bus.mem_req, 1);
            check("to_acc_terr", bus.timeout_err, 0);
        end
        @(negedge clk);
        #1;
        check("to_done_req", bus.mem_req, 0);
        check("to_done_pipe_en", bus.pipe_en, 1);
        check("to_done_rd", bus.read_data, 32'hDEAD_BEEF);
        check("to_done_terr", bus.timeout_err, 1);
        bus.MEM_R_en = 1'b0;
        rd_model     = 32'hDEAD_BEEF;
        terr_model   = 1'b1;
        run_txn(mk("post_to", 0, 1, 32'h700, 32'h0F0F0F0F, 32'h0, 2, 1, 32'hDEAD_BEEF, 1));
        @(negedge clk);
        rst = 1'b1;
        #1 check("to_rst_clear", bus.timeout_err, 0);
        @(negedge clk);
        rst        = 1'b0;
        terr_model = 1'b0;
        rd_model   = 32'h0;
        #1 idle_checks("to_after_rst");
`else
        // Without the timeout the controller waits as long as it takes.
        @(negedge clk);
        bus.MEM_R_en = 1'b1;
        bus.address  = 32'h600;
        #1 check("wait_issue_pipe_en", bus.pipe_en, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("wait_acc_req", bus.mem_req, 1);
            check("wait_terr", bus.timeout_err, 0);
        end
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h600D_DA7A;
        #1 check("wait_last_req", bus.mem_req, 1);
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.MEM_R_en = 1'b0;
        #1;
        check("wait_done_rd", bus.read_data, 32'h600D_DA7A);
        check("wait_done_pipe_en", bus.pipe_en, 1);
        rd_model = 32'h600D_DA7A;
        @(negedge clk);
        #1 idle_checks("wait_after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
